// File: rtl/sr_pulse_filter.sv
`default_nettype none
// ============================================================================
//  Module      : sr_pulse_filter
//  Description : Input conditioner for a NOR-based SR latch. Synchronizes raw
//                set/reset requests, rejects pulses shorter than MIN_WIDTH
//                clocks, never drives s=r=1, tracks the expected latch state
//                and counts rejected glitches (saturating).
//                Optional macro SR_SET_PRIORITY_EN makes the CONFLICT state
//                set-dominant (s_out=1, q_shadow set on entry).
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_pulse_filter #(
    parameter int MIN_WIDTH = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_in,
    input  logic             r_in,
    output logic             s_out,
    output logic             r_out,
    output logic             conflict,
    output logic             q_shadow,
    output logic [CNT_W-1:0] glitch_count
);

    // Filter counter must be able to hold MIN_WIDTH-1.
    localparam int             CW       = $clog2(MIN_WIDTH) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(MIN_WIDTH - 1);
    localparam logic [CNT_W:0] GLT_MAX  = {1'b0, {CNT_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_SET      = 2'b01,
        ST_RESET    = 2'b10,
        ST_CONFLICT = 2'b11
    } state_t;

    // Channel index 1 = set, 0 = reset, so {s,r} concatenations line up.
    logic [1:0]    w_raw;
    logic [1:0]    meta_q;
    logic [1:0]    sync_q;
    logic [1:0]    filt_q;
    logic [1:0]    w_reject;
    logic [CW-1:0] cnt_q [2];

    logic [CNT_W-1:0] glitch_q;
    logic [CNT_W-1:0] glitch_d;
    logic [CNT_W:0]   w_glitch_sum;

    state_t state_q;
    state_t state_d;
    logic   s_out_q;
    logic   r_out_q;
    logic   conflict_q;
    logic   q_shadow_q;

    assign w_raw = {s_in, r_in};

    generate
        for (genvar c = 0; c < 2; c++) begin : g_chan
            // Two-flop synchronizer for the raw request of this channel.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    meta_q[c] <= 1'b0;
                    sync_q[c] <= 1'b0;
                end else begin
                    meta_q[c] <= w_raw[c];
                    sync_q[c] <= meta_q[c];
                end
            end

            // Accept a new level only after MIN_WIDTH consecutive differing edges.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    filt_q[c] <= 1'b0;
                    cnt_q[c]  <= '0;
                end else if (sync_q[c] == filt_q[c]) begin
                    cnt_q[c]  <= '0;
                end else if (cnt_q[c] == CNT_LAST) begin
                    filt_q[c] <= sync_q[c];
                    cnt_q[c]  <= '0;
                end else begin
                    cnt_q[c]  <= cnt_q[c] + CW'(1);
                end
            end

            // A pulse that collapsed back before acceptance is a glitch.
            assign w_reject[c] = (sync_q[c] == filt_q[c]) && (cnt_q[c] != '0);
        end
    endgenerate

    // Add 0, 1 or 2 rejections this cycle, clamped at the all-ones value.
    always_comb begin
        w_glitch_sum = {1'b0, glitch_q}
                     + (CNT_W + 1)'(w_reject[0])
                     + (CNT_W + 1)'(w_reject[1]);
        glitch_d     = glitch_q;
        if (w_glitch_sum > GLT_MAX) begin
            glitch_d = GLT_MAX[CNT_W-1:0];
        end else begin
            glitch_d = w_glitch_sum[CNT_W-1:0];
        end
    end

    // Saturating glitch counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    // Next state follows the filtered pair directly; any-to-any in one edge.
    always_comb begin
        state_d = ST_IDLE;
        case (filt_q)
            2'b00:   state_d = ST_IDLE;
            2'b10:   state_d = ST_SET;
            2'b01:   state_d = ST_RESET;
            default: state_d = ST_CONFLICT;
        endcase
    end

    // Moore FSM with registered outputs and shadow latch state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            s_out_q    <= 1'b0;
            r_out_q    <= 1'b0;
            conflict_q <= 1'b0;
            q_shadow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_out_q    <= 1'b0;
            r_out_q    <= 1'b0;
            conflict_q <= 1'b0;
            case (state_d)
                ST_SET: begin
                    s_out_q <= 1'b1;
                    if (state_q != ST_SET) begin
                        q_shadow_q <= 1'b1;
                    end
                end
                ST_RESET: begin
                    r_out_q <= 1'b1;
                    if (state_q != ST_RESET) begin
                        q_shadow_q <= 1'b0;
                    end
                end
                ST_CONFLICT: begin
                    conflict_q <= 1'b1;
`ifdef SR_SET_PRIORITY_EN
                    s_out_q    <= 1'b1;
                    if (state_q != ST_CONFLICT) begin
                        q_shadow_q <= 1'b1;
                    end
`else
                    // Latch inputs both released; latch holds its value.
`endif
                end
                default: begin
                    // IDLE: outputs low, shadow holds.
                end
            endcase
        end
    end

    assign s_out        = s_out_q;
    assign r_out        = r_out_q;
    assign conflict     = conflict_q;
    assign q_shadow     = q_shadow_q;
    assign glitch_count = glitch_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_pulse_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_pulse_filter
//  Description : Scoreboard bench for sr_pulse_filter. Two instances share the
//                stimulus: dut (CNT_W=8) and dut2 (CNT_W=2, for saturation).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_pulse_filter;

`ifdef SR_SET_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_in = 1'b0;
    logic       r_in = 1'b0;
    logic       s_out, r_out, conflict, q_shadow;
    logic [7:0] glitch_count;
    logic       s_out2, r_out2, conflict2, q_shadow2;
    logic [1:0] glitch_count2;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic       s;
        logic       r;
        logic       c;
        logic       q;
        logic [7:0] g;
        logic [1:0] g2;
    } exp_t;

    exp_t sb[$];

    sr_pulse_filter #(.MIN_WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .s_in(s_in), .r_in(r_in),
        .s_out(s_out), .r_out(r_out), .conflict(conflict),
        .q_shadow(q_shadow), .glitch_count(glitch_count)
    );

    sr_pulse_filter #(.MIN_WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .s_in(s_in), .r_in(r_in),
        .s_out(s_out2), .r_out(r_out2), .conflict(conflict2),
        .q_shadow(q_shadow2), .glitch_count(glitch_count2)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic s, r, c, q, input int g, g2);
        exp_t e;
        e.s  = s;
        e.r  = r;
        e.c  = c;
        e.q  = q;
        e.g  = 8'(g);
        e.g2 = 2'(g2);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // One clock: drive inputs just after the edge and queue the outputs
    // expected to be visible after that edge.
    task automatic cyc(input logic rst_v, input logic s_v, input logic r_v, input exp_t e);
        @(posedge clk);
        #1;
        reset = rst_v;
        s_in  = s_v;
        r_in  = r_v;
        sb.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("s_out",         8'(s_out),     8'(e.s));
                chk("r_out",         8'(r_out),     8'(e.r));
                chk("conflict",      8'(conflict),  8'(e.c));
                chk("q_shadow",      8'(q_shadow),  8'(e.q));
                chk("glitch_count",  glitch_count,  e.g);
                chk("s_out2",        8'(s_out2),    8'(e.s));
                chk("r_out2",        8'(r_out2),    8'(e.r));
                chk("conflict2",     8'(conflict2), 8'(e.c));
                chk("q_shadow2",     8'(q_shadow2), 8'(e.q));
                chk("glitch_count2", 8'(glitch_count2), 8'(e.g2));
            end
        end
    end

    initial begin
        logic q;
        int   g;
        int   g2;
        logic win;
        q  = 1'b0;
        g  = 0;
        g2 = 0;

        // Reset held, then 20 idle cycles.
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0));

        // Clean 10-cycle set: s_out high after edges 7..16.
        for (int i = 0; i < 24; i++) begin
            win = (i >= 7 && i < 17);
            if (i == 7) q = 1'b1;
            cyc(1'b0, i < 10, 1'b0, mk(win, 0, 0, q, g, g2));
        end

        // 3-cycle set pulse rejected; counted at edge 6.
        for (int i = 0; i < 12; i++) begin
            if (i == 6) begin
                g++;
                g2++;
            end
            cyc(1'b0, i < 3, 1'b0, mk(0, 0, 0, q, g, g2));
        end

        // 4-cycle set pulse accepted: s_out high after edges 7..10.
        for (int i = 0; i < 16; i++) begin
            win = (i >= 7 && i < 11);
            cyc(1'b0, i < 4, 1'b0, mk(win, 0, 0, q, g, g2));
        end

        // Simultaneous set and reset for 10 cycles: CONFLICT after edges 7..16.
        for (int i = 0; i < 22; i++) begin
            win = (i >= 7 && i < 17);
            if (PRIO && i == 7) q = 1'b1;
            cyc(1'b0, i < 10, i < 10, mk(PRIO ? win : 1'b0, 0, win, q, g, g2));
        end

        // Clean 6-cycle reset: r_out high after edges 7..12, q cleared.
        for (int i = 0; i < 16; i++) begin
            win = (i >= 7 && i < 13);
            if (i == 7) q = 1'b0;
            cyc(1'b0, 1'b0, i < 6, mk(0, win, 0, q, g, g2));
        end

        // Reset mid-filter (cnt=3 after edge 5), held through edge 6.
        // After release s_out rises 7 edges later (edge 13), falls at edge 23.
        for (int i = 0; i < 28; i++) begin
            if (i == 5) begin
                q  = 1'b0;
                g  = 0;
                g2 = 0;
            end
            if (i == 13) q = 1'b1;
            win = (i >= 13 && i < 23);
            cyc((i == 5), i < 16, 1'b0, mk(win, 0, 0, q, g, g2));
        end

        // Five 1-cycle reset pulses; each counted at edge 4 of its slot.
        // dut2 saturates at 3.
        for (int p = 0; p < 5; p++) begin
            for (int j = 0; j < 6; j++) begin
                if (j == 4) begin
                    g++;
                    if (g2 < 3) g2++;
                end
                cyc(1'b0, 1'b0, (j == 0), mk(0, 0, 0, q, g, g2));
            end
        end

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, q, g, g2));

        // Let the monitor drain the remaining entries, bounded.
        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
